// File: rtl/alu_mem_wb.sv
// Back end of the 16-bit teaching CPU: EX (ALU), MEM (256x16 data memory) and WB stages.
// Define ALU_MUL_EN to enable op 1010 as a 16-bit MUL; undefined, op 1010 is a NOP.
module alu_mem_wb (
  input  logic        clock,
  input  logic        reset,
  input  logic [55:0] idbus,
  output logic [19:0] wbbus,
  output logic [2:0]  ex_dest,
  output logic [2:0]  mem_dest,
  output logic [2:0]  wb_dest,
  output logic [39:0] exbus,
  output logic [39:0] membus
);

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_LD  = 4'b1000;
  localparam logic [3:0] OP_ST  = 4'b1001;
  localparam logic [3:0] OP_MUL = 4'b1010;
  localparam int STAGES = 2;

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  dest;
    logic [15:0] result;
    logic [15:0] stv;
  } stage_t;

  // vld_pipe[0]=EX, [1]=MEM, [2]=WB
  logic [STAGES:0] vld_pipe;
  stage_t          ex_q, mem_q;
  logic [3:0]      wb_op;
  logic [2:0]      wb_dq;
  logic [15:0]     wb_res;
  logic [15:0]     dmem [256];

  function automatic logic writes_reg(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_SLL, OP_SRL, OP_LD: writes_reg = 1'b1;
`ifdef ALU_MUL_EN
      OP_MUL:                        writes_reg = 1'b1;
`else
      OP_MUL:                        writes_reg = 1'b0;
`endif
      OP_NOP, OP_ST:                 writes_reg = 1'b0;
      default:                       writes_reg = 1'b0;
    endcase
  endfunction

  // r0 is never a real destination, so it doubles as "no hazard"
  function automatic logic [2:0] rpt_dest(input logic v, input logic [3:0] op, input logic [2:0] d);
    rpt_dest = (v && writes_reg(op)) ? d : 3'd0;
  endfunction

  logic        id_vld;
  logic [3:0]  id_op;
  logic [2:0]  id_dest;
  logic [15:0] v1, v2, id_stv;
  assign {id_vld, id_op, id_dest, v1, v2, id_stv} = idbus;

  logic [15:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (id_op)
      OP_ADD:        alu_res = v1 + v2;
      OP_SUB:        alu_res = v1 - v2;
      OP_AND:        alu_res = v1 & v2;
      OP_OR:         alu_res = v1 | v2;
      OP_XOR:        alu_res = v1 ^ v2;
      OP_SLL:        alu_res = v1 << v2[3:0];
      OP_SRL:        alu_res = v1 >> v2[3:0];
      OP_LD, OP_ST:  alu_res = v1 + v2;
`ifdef ALU_MUL_EN
      OP_MUL:        alu_res = v1 * v2;
`else
      OP_MUL:        alu_res = '0;
`endif
      default:       alu_res = '0;
    endcase
  end

  // Asynchronous read so a store committed on this edge is seen by a load entering MEM on it
  logic [15:0] mem_res;
  assign mem_res = (mem_q.op == OP_LD) ? dmem[mem_q.result[7:0]] : mem_q.result;

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe <= '0;
      ex_q     <= '0;
      mem_q    <= '0;
      wb_op    <= '0;
      wb_dq    <= '0;
      wb_res   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], id_vld};
      ex_q     <= id_vld ? '{op: id_op, dest: id_dest, result: alu_res, stv: id_stv} : '0;
      mem_q    <= ex_q;
      wb_op    <= mem_q.op;
      wb_dq    <= mem_q.dest;
      wb_res   <= mem_res;
    end
  end

  // Data memory has no reset; a store in MEM at a reset edge is dropped
  always_ff @(posedge clock) begin
    if (!reset && vld_pipe[1] && mem_q.op == OP_ST)
      dmem[mem_q.result[7:0]] <= mem_q.stv;
  end

  assign ex_dest  = rpt_dest(vld_pipe[0], ex_q.op, ex_q.dest);
  assign mem_dest = rpt_dest(vld_pipe[1], mem_q.op, mem_q.dest);
  assign wb_dest  = rpt_dest(vld_pipe[2], wb_op, wb_dq);

  assign exbus  = {vld_pipe[0], ex_q.op, ex_q.dest, ex_q.result, ex_q.stv};
  assign membus = {vld_pipe[1], mem_q.op, mem_q.dest, mem_res, 16'h0000};
  assign wbbus  = {(wb_dest != 3'd0), wb_dest, wb_res};

endmodule

// File: tb/tb_alu_mem_wb.sv
// Directed-vector bench for alu_mem_wb; build with +define+ALU_MUL_EN to check the MUL variant.
module tb_alu_mem_wb;
  logic        clock;
  logic        reset;
  logic [55:0] idbus;
  logic [19:0] wbbus;
  logic [2:0]  ex_dest, mem_dest, wb_dest;
  logic [39:0] exbus, membus;

  int n_tests = 0;
  int n_fail  = 0;

  alu_mem_wb dut (
    .clock(clock), .reset(reset), .idbus(idbus), .wbbus(wbbus),
    .ex_dest(ex_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
    .exbus(exbus), .membus(membus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [55:0] mk(input logic [3:0] op, input logic [2:0] d,
                                     input logic [15:0] a, input logic [15:0] b, input logic [15:0] s);
    mk = {1'b1, op, d, a, b, s};
  endfunction

  logic [55:0] seq_in  [6];
  logic [19:0] seq_exp [6];

  initial begin
    reset = 1'b1;
    idbus = '0;

    // reset held two clocks
    tick(); tick();
    chk("rst_wbbus", wbbus, 0);
    chk("rst_exbus", exbus, 0);
    chk("rst_membus", membus, 0);
    chk("rst_ex_dest", ex_dest, 0);
    chk("rst_mem_dest", mem_dest, 0);
    chk("rst_wb_dest", wb_dest, 0);

    reset = 1'b0;
    tick(); tick(); tick();
    chk("bub_wbbus", wbbus, 0);
    chk("bub_exbus", exbus, 0);
    chk("bub_membus", membus, 0);

    // ADD latency
    idbus = mk(4'b0001, 3'd3, 16'h7FFF, 16'h0002, 16'h0);
    tick();
    idbus = '0;
    chk("add_ex_dest", ex_dest, 3);
    chk("add_ex_res", exbus[31:16], 16'h8001);
    chk("add_ex_vld", exbus[39], 1);
    tick();
    chk("add_mem_dest", mem_dest, 3);
    chk("add_ex_dest_bub", ex_dest, 0);
    tick();
    chk("add_wbbus", wbbus, 20'hB8001);
    chk("add_wb_dest", wb_dest, 3);

    // back-to-back ALU ops, dest r1
    seq_in[0] = mk(4'b0010, 3'd1, 16'hF0F0, 16'h0004, 16'h0); seq_exp[0] = 20'h9F0EC;
    seq_in[1] = mk(4'b0011, 3'd1, 16'hF0F0, 16'h0004, 16'h0); seq_exp[1] = 20'h90000;
    seq_in[2] = mk(4'b0100, 3'd1, 16'hF0F0, 16'h0004, 16'h0); seq_exp[2] = 20'h9F0F4;
    seq_in[3] = mk(4'b0101, 3'd1, 16'hF0F0, 16'h0004, 16'h0); seq_exp[3] = 20'h9F0F4;
    seq_in[4] = mk(4'b0110, 3'd1, 16'hF0F0, 16'h0004, 16'h0); seq_exp[4] = 20'h90F00;
    seq_in[5] = mk(4'b0111, 3'd1, 16'hF0F0, 16'h0004, 16'h0); seq_exp[5] = 20'h90F0F;
    for (int i = 0; i < 8; i++) begin
      idbus = (i < 6) ? seq_in[i] : 56'h0;
      tick();
      if (i >= 2) chk($sformatf("b2b_wbbus_%0d", i - 2), wbbus, seq_exp[i-2]);
    end
    idbus = '0;
    tick();
    chk("b2b_drain", wbbus[19], 0);

    // ST then LD back-to-back
    idbus = mk(4'b1001, 3'd0, 16'h0100, 16'h0005, 16'hBEEF);
    tick();
    chk("st_ex_dest", ex_dest, 0);
    chk("st_ex_stv", exbus[15:0], 16'hBEEF);
    idbus = mk(4'b1000, 3'd2, 16'h0005, 16'h0000, 16'h0);
    tick();
    idbus = '0;
    chk("st_mem_dest", mem_dest, 0);
    chk("ld_ex_dest", ex_dest, 2);
    tick();
    chk("st_wb_vld", wbbus[19], 0);
    chk("ld_mem_res", membus[31:16], 16'hBEEF);
    tick();
    chk("ld_wbbus", wbbus, 20'hABEEF);

    // dest r0 and undefined opcode
    idbus = mk(4'b0001, 3'd0, 16'h0001, 16'h0001, 16'h0);
    tick();
    chk("d0_ex_dest", ex_dest, 0);
    idbus = mk(4'b1111, 3'd5, 16'h0001, 16'h0001, 16'h0);
    tick();
    idbus = '0;
    chk("undef_ex_dest", ex_dest, 0);
    chk("d0_mem_dest", mem_dest, 0);
    tick();
    chk("d0_wb_vld", wbbus[19], 0);
    chk("d0_wb_dest", wb_dest, 0);
    chk("undef_mem_dest", mem_dest, 0);
    tick();
    chk("undef_wb_vld", wbbus[19], 0);
    chk("undef_wb_dest", wb_dest, 0);

    // reset drops a store sitting in MEM
    idbus = mk(4'b1001, 3'd0, 16'h0007, 16'h0000, 16'h5555);
    tick();
    idbus = '0;
    tick(); tick();
    idbus = mk(4'b1001, 3'd0, 16'h0007, 16'h0000, 16'h1234);
    tick();
    idbus = mk(4'b0001, 3'd4, 16'h0001, 16'h0001, 16'h0);
    tick();
    idbus = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("flush_exbus", exbus, 0);
    chk("flush_membus", membus, 0);
    chk("flush_wbbus", wbbus, 0);
    chk("flush_mem_dest", mem_dest, 0);
    idbus = mk(4'b1000, 3'd4, 16'h0007, 16'h0000, 16'h0);
    tick();
    idbus = '0;
    tick(); tick();
    chk("rst_st_ld_wbbus", wbbus, 20'hC5555);

    // op 1010
    idbus = mk(4'b1010, 3'd6, 16'h0100, 16'h0300, 16'h0);
    tick();
    idbus = '0;
    tick(); tick();
`ifdef ALU_MUL_EN
    chk("mul_wbbus", wbbus, 20'hE0000);
    chk("mul_wb_dest", wb_dest, 6);
`else
    chk("mul_off_wb_vld", wbbus[19], 0);
    chk("mul_off_wb_dest", wb_dest, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
